// File: rtl/memory_access_cycle_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// funct3 decode helpers keep the load and store paths in agreement on access size.
package memory_access_cycle_pkg;

    localparam int unsigned Xlen = 32;
    localparam int unsigned BeW  = Xlen / 8;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    typedef enum logic {StIdle, StAccess} state_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    typedef struct packed {
        logic [Xlen-1:0] alu;
        logic [Xlen-1:0] sdata;
        logic [Xlen-1:0] pc;
        logic [4:0]      waddr;
        logic [2:0]      funct3;
        logic            jtype;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } stage_t;

    typedef struct packed {
        logic [Xlen-1:0] alu;
        logic [Xlen-1:0] load;
        logic [Xlen-1:0] pc;
        logic [4:0]      waddr;
        logic            reg_write;
        logic            mem_read;
        logic            jtype;
        logic            misaligned;
        logic            mem_fault;
    } wb_t;

    // Unlisted funct3 codes fall back to a word access.
    function automatic size_e access_size(logic [2:0] f3);
        case (f3)
            F3Lb, F3Lbu: return SzByte;
            F3Lh, F3Lhu: return SzHalf;
            default:     return SzWord;
        endcase
    endfunction

    function automatic size_e store_size(logic [2:0] f3);
        case (f3)
            F3Sb:    return SzByte;
            F3Sh:    return SzHalf;
            F3Sw:    return SzWord;
            default: return access_size(f3);
        endcase
    endfunction

    function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] addr_lo);
        case (access_size(f3))
            SzHalf:  return addr_lo[0];
            SzWord:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_cycle_if.sv
// Data-memory request/ready bus between the memory-access stage and the data memory.
interface memory_access_cycle_if;
    import memory_access_cycle_pkg::*;

    logic            read;
    logic            write;
    logic [Xlen-1:0] addr;
    logic [Xlen-1:0] wdata;
    logic [BeW-1:0]  be;
    logic [Xlen-1:0] rdata;
    logic            ready;

    modport master (
        output read, write, addr, wdata, be,
        input  rdata, ready
    );

    modport slave (
        input  read, write, addr, wdata, be,
        output rdata, ready
    );

endinterface

// File: rtl/memory_access_cycle_load_extender.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module memory_access_cycle_load_extender
    import memory_access_cycle_pkg::*;
(
    input  logic [Xlen-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [2:0]      funct3_i,
    output logic [Xlen-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[8*addr_i +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3Lb:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3Lbu:   data_o = {24'h0, byte_sel};
            F3Lh:    data_o = {{16{half_sel[15]}}, half_sel};
            F3Lhu:   data_o = {16'h0, half_sel};
            F3Lw:    data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_cycle.sv
// Memory-access pipeline stage: registers EX results, runs data-memory loads/stores with a
// bounded ready wait, and presents registered results to write-back.
module memory_access_cycle
    import memory_access_cycle_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [Xlen-1:0]      alu_out_m_i,
    input  logic [Xlen-1:0]      store_data_m_i,
    input  logic [Xlen-1:0]      pc_plus_imm_m_i,
    input  logic [4:0]           write_address_m_i,
    input  logic [5:0]           alu_select_m_i,
    input  logic                 jtype_m_i,
    input  logic                 reg_write_m_i,
    input  logic                 mem_read_m_i,
    input  logic                 mem_write_m_i,
    memory_access_cycle_if.master dmem_io,
    output logic                 stall_m_o,
    output logic [Xlen-1:0]      alu_out_w_o,
    output logic [Xlen-1:0]      load_data_w_o,
    output logic [Xlen-1:0]      pc_plus_imm_w_o,
    output logic [4:0]           write_address_w_o,
    output logic                 reg_write_w_o,
    output logic                 mem_read_w_o,
    output logic                 jtype_w_o,
    output logic                 misaligned_w_o,
    output logic                 mem_fault_w_o
);

    localparam int unsigned     CntW     = ($clog2(TimeoutCycles) > 0) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);

    stage_t          stage_in, stage_q;
    logic            valid_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    wb_t             wb_q, wb_d;
    logic [Xlen-1:0] load_ext;
    size_e           st_size;
    logic            unused_sel;
    logic            mem_op_q, misal_q, start_in, in_access, stall, done, timeout, retire;

    assign unused_sel = ^alu_select_m_i[5:3];

    assign stage_in = '{alu:       alu_out_m_i,
                        sdata:     store_data_m_i,
                        pc:        pc_plus_imm_m_i,
                        waddr:     write_address_m_i,
                        funct3:    alu_select_m_i[2:0],
                        jtype:     jtype_m_i,
                        reg_write: reg_write_m_i,
                        mem_read:  mem_read_m_i,
                        mem_write: mem_write_m_i};

    assign start_in  = (mem_read_m_i | mem_write_m_i)
                     & ~is_misaligned(alu_select_m_i[2:0], alu_out_m_i[1:0]);
    assign mem_op_q  = stage_q.mem_read | stage_q.mem_write;
    assign misal_q   = is_misaligned(stage_q.funct3, stage_q.alu[1:0]);
    assign in_access = (state_q == StAccess);
    assign stall     = in_access & ~dmem_io.ready;
    assign done      = in_access & dmem_io.ready;
    assign timeout   = stall & (cnt_q == CntLimit);
    assign stall_m_o = stall;

    // Request is driven only while an access is outstanding; read wins over write.
    always_comb begin
        st_size       = store_size(stage_q.funct3);
        dmem_io.read  = 1'b0;
        dmem_io.write = 1'b0;
        dmem_io.addr  = '0;
        dmem_io.wdata = '0;
        dmem_io.be    = '0;
        if (in_access) begin
            dmem_io.read  = stage_q.mem_read;
            dmem_io.write = stage_q.mem_write & ~stage_q.mem_read;
            dmem_io.addr  = {stage_q.alu[Xlen-1:2], 2'b00};
            case (st_size)
                SzByte: begin
                    dmem_io.be    = 4'b0001 << stage_q.alu[1:0];
                    dmem_io.wdata = {4{stage_q.sdata[7:0]}};
                end
                SzHalf: begin
                    dmem_io.be    = 4'b0011 << {stage_q.alu[1], 1'b0};
                    dmem_io.wdata = {2{stage_q.sdata[15:0]}};
                end
                default: begin
                    dmem_io.be    = 4'b1111;
                    dmem_io.wdata = stage_q.sdata;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                end
            end
            StAccess: begin
                if (dmem_io.ready) begin
                    state_d = start_in ? StAccess : StIdle;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    memory_access_cycle_load_extender u_load_extender (
        .rdata_i  (dmem_io.rdata),
        .addr_i   (stage_q.alu[1:0]),
        .funct3_i (stage_q.funct3),
        .data_o   (load_ext)
    );

    // In IDLE an aligned memory op is never pending, so a valid memory op there is misaligned.
    always_comb begin
        wb_d            = wb_q;
        wb_d.reg_write  = 1'b0;
        wb_d.mem_read   = 1'b0;
        wb_d.misaligned = 1'b0;
        wb_d.mem_fault  = 1'b0;
        retire = done | timeout | (~in_access & valid_q & (~mem_op_q | misal_q));
        if (retire) begin
            wb_d.alu   = stage_q.alu;
            wb_d.pc    = stage_q.pc;
            wb_d.waddr = stage_q.waddr;
            wb_d.jtype = stage_q.jtype;
        end
        if (done) begin
            if (stage_q.mem_read) begin
                wb_d.reg_write = stage_q.reg_write;
                wb_d.mem_read  = 1'b1;
                wb_d.load      = load_ext;
            end
        end else if (timeout) begin
            wb_d.mem_fault = 1'b1;
        end else if (retire) begin
            if (mem_op_q) begin
                wb_d.misaligned = 1'b1;
            end else begin
                wb_d.reg_write = stage_q.reg_write;
            end
        end
    end

    // valid_q drops on abort so the held, aborted op is never retired again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stage_q <= '0;
            valid_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            if (!stall) begin
                stage_q <= stage_in;
                valid_q <= 1'b1;
            end else if (timeout) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign alu_out_w_o       = wb_q.alu;
    assign load_data_w_o     = wb_q.load;
    assign pc_plus_imm_w_o   = wb_q.pc;
    assign write_address_w_o = wb_q.waddr;
    assign reg_write_w_o     = wb_q.reg_write;
    assign mem_read_w_o      = wb_q.mem_read;
    assign jtype_w_o         = wb_q.jtype;
    assign misaligned_w_o    = wb_q.misaligned;
    assign mem_fault_w_o     = wb_q.mem_fault;

endmodule

// File: tb/tb_memory_access_cycle.sv
// Bench for memory_access_cycle: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the stage.
module tb_memory_access_cycle;

    localparam int unsigned Timeout = 4;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  wa;
        logic [5:0]  sel;
        logic        jt;
        logic        rw;
        logic        mr;
        logic        mw;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    ins_t        drv = '0;
    logic        rdy = 1'b0;
    logic [31:0] rdat = '0;

    logic        stall_w;
    logic [31:0] alu_w, load_w, pc_w;
    logic [4:0]  wa_w;
    logic        rw_w, mr_w, jt_w, mis_w, flt_w;

    always #5 clk = ~clk;

    memory_access_cycle_if dmem ();
    assign dmem.ready = rdy;
    assign dmem.rdata = rdat;

    memory_access_cycle #(.TimeoutCycles(Timeout)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .alu_out_m_i       (drv.alu),
        .store_data_m_i    (drv.sd),
        .pc_plus_imm_m_i   (drv.pc),
        .write_address_m_i (drv.wa),
        .alu_select_m_i    (drv.sel),
        .jtype_m_i         (drv.jt),
        .reg_write_m_i     (drv.rw),
        .mem_read_m_i      (drv.mr),
        .mem_write_m_i     (drv.mw),
        .dmem_io           (dmem),
        .stall_m_o         (stall_w),
        .alu_out_w_o       (alu_w),
        .load_data_w_o     (load_w),
        .pc_plus_imm_w_o   (pc_w),
        .write_address_w_o (wa_w),
        .reg_write_w_o     (rw_w),
        .mem_read_w_o      (mr_w),
        .jtype_w_o         (jt_w),
        .misaligned_w_o    (mis_w),
        .mem_fault_w_o     (flt_w)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: the op sitting in the stage, whether its access is outstanding, and cycles waited.
    ins_t        m_ins;
    bit          m_valid, m_busy;
    int          m_wait;
    logic [31:0] e_alu, e_load, e_pc;
    logic [4:0]  e_wa;
    logic        e_rw, e_mr, e_jt, e_mis, e_flt;

    logic        s_stall, s_rd, s_wr;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_be;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit is_mem(input ins_t i);
        return i.mr || i.mw;
    endfunction

    function automatic bit misal(input ins_t i);
        return is_mem(i) && ((int'(i.alu[1:0]) % sz(i.sel[2:0])) != 0);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input ins_t i);
        int n = sz(i.sel[2:0]);
        int off = int'(i.alu[1:0]);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
        if ((i.sel[2:0] == 3'd0 || i.sel[2:0] == 3'd1) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [31:0] store_val(input ins_t i);
        int n = sz(i.sel[2:0]);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = i.sd[8*(k % n) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] lanes(input ins_t i);
        logic [7:0] t = ((8'd1 << sz(i.sel[2:0])) - 8'd1) << i.alu[1:0];
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_ins = '0; m_valid = 0; m_busy = 0; m_wait = 0;
        e_alu = '0; e_load = '0; e_pc = '0; e_wa = '0;
        e_rw = 0; e_mr = 0; e_jt = 0; e_mis = 0; e_flt = 0;
    endtask

    task automatic check_wb();
        check("alu_w", alu_w, e_alu);
        check("load_w", load_w, e_load);
        check("pc_w", pc_w, e_pc);
        check("wa_w", 32'(wa_w), 32'(e_wa));
        check("rw_w", 32'(rw_w), 32'(e_rw));
        check("mr_w", 32'(mr_w), 32'(e_mr));
        check("jt_w", 32'(jt_w), 32'(e_jt));
        check("mis_w", 32'(mis_w), 32'(e_mis));
        check("flt_w", 32'(flt_w), 32'(e_flt));
    endtask

    // One clock: drive, compare everything against the model, advance the model, cross the edge.
    task automatic cycle(input ins_t in, input logic r, input logic [31:0] d);
        bit   e_stall, capture;
        int   kind;
        @(negedge clk);
        drv = in; rdy = r; rdat = d;
        #1;
        s_stall = stall_w; s_rd = dmem.read; s_wr = dmem.write;
        s_addr = dmem.addr; s_wd = dmem.wdata; s_be = dmem.be;
        e_stall = m_busy && !r;
        check("stall", 32'(s_stall), 32'(e_stall));
        check("read", 32'(s_rd), 32'(m_busy && m_ins.mr));
        check("write", 32'(s_wr), 32'(m_busy && m_ins.mw && !m_ins.mr));
        check("addr", s_addr, m_busy ? m_ins.alu - (m_ins.alu % 4) : 32'h0);
        check("wdata", s_wd, m_busy ? store_val(m_ins) : 32'h0);
        check("be", 32'(s_be), m_busy ? 32'(lanes(m_ins)) : 32'h0);
        check_wb();

        e_rw = 0; e_mr = 0; e_mis = 0; e_flt = 0;
        kind = 0;
        if (m_busy) begin
            if (r) kind = 2;
            else if (m_wait == Timeout - 1) kind = 4;
            else m_wait++;
        end else if (m_valid) begin
            kind = is_mem(m_ins) ? 3 : 1;
        end
        if (kind != 0) begin
            e_alu = m_ins.alu; e_pc = m_ins.pc; e_wa = m_ins.wa; e_jt = m_ins.jt;
        end
        case (kind)
            1: e_rw = m_ins.rw;
            2: if (m_ins.mr) begin e_rw = m_ins.rw; e_mr = 1; e_load = load_val(d, m_ins); end
            3: e_mis = 1;
            4: begin e_flt = 1; m_busy = 0; m_valid = 0; end
            default: ;
        endcase
        capture = !e_stall;
        if (capture) begin
            m_ins = in; m_valid = 1; m_wait = 0;
            m_busy = is_mem(in) && !misal(in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rdy = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("rst_read", 32'(dmem.read), 32'h0);
        check("rst_stall", 32'(stall_w), 32'h0);
        check("rst_alu_w", alu_w, 32'h0);
        check("rst_load_w", load_w, 32'h0);
        check("rst_ctl_w", {27'h0, rw_w, mr_w, jt_w, mis_w, flt_w}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    function automatic ins_t rand_ins();
        ins_t i = '0;
        int k = $urandom_range(0, 19);
        i.alu = $urandom; i.sd = $urandom; i.pc = $urandom;
        i.wa = 5'($urandom); i.sel = 6'($urandom); i.jt = 1'($urandom); i.rw = 1'($urandom);
        if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
        i.mr = (k >= 6 && k < 13) || k == 19;
        i.mw = k >= 13;
        return i;
    endfunction

    ins_t nop, t;
    int   stalls;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nop = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall_w), 32'h0);
        check("reset_read", 32'(dmem.read), 32'h0);
        check_wb();
        rst_ni = 1'b1;

        // ALU op passes through with one cycle of latency
        t = '0; t.alu = 32'h1234; t.rw = 1; t.wa = 5'd5;
        cycle(t, 1'b0, 32'h0);
        cycle(nop, 1'b0, 32'h0);
        check("alu_stall", 32'(s_stall), 32'h0);
        check("alu_strobe", 32'({s_rd, s_wr}), 32'h0);
        check("alu_out", alu_w, 32'h1234);
        check("alu_rw", 32'(rw_w), 32'h1);
        check("alu_wa", 32'(wa_w), 32'd5);

        // LB at 0x103, ready on the third access cycle
        t = '0; t.alu = 32'h103; t.sel = 6'd0; t.mr = 1; t.rw = 1; t.wa = 5'd7;
        cycle(t, 1'b0, 32'h0);
        stalls = 0;
        cycle(nop, 1'b0, 32'hDEAD_BEEF); stalls += int'(s_stall);
        check("lb_addr", s_addr, 32'h100);
        cycle(nop, 1'b0, 32'h1111_2222); stalls += int'(s_stall);
        check("lb_read", 32'(s_rd), 32'h1);
        cycle(nop, 1'b1, 32'h80FF_7F01); stalls += int'(s_stall);
        check("lb_stalls", 32'(stalls), 32'd2);
        check("lb_data", load_w, 32'hFFFF_FF80);
        check("lb_rw", 32'({rw_w, mr_w}), 32'h3);
        cycle(nop, 1'b0, 32'h0);
        check("lb_mr_once", 32'(mr_w), 32'h0);

        // SH at 0x202 completing in the first access cycle
        t = '0; t.alu = 32'h202; t.sd = 32'h0000_ABCD; t.sel = 6'd1; t.mw = 1; t.rw = 1;
        cycle(t, 1'b0, 32'h0);
        cycle(nop, 1'b1, 32'h0);
        check("sh_be", 32'(s_be), 32'hC);
        check("sh_wdata", s_wd, 32'hABCD_ABCD);
        check("sh_stall", 32'(s_stall), 32'h0);
        check("sh_rw", 32'(rw_w), 32'h0);

        // Misaligned LW at 0x101
        t = '0; t.alu = 32'h101; t.sel = 6'd2; t.mr = 1; t.rw = 1;
        cycle(t, 1'b0, 32'h0);
        cycle(nop, 1'b0, 32'h0);
        check("lw_mis_read", 32'(s_rd), 32'h0);
        check("lw_mis_stall", 32'(s_stall), 32'h0);
        check("lw_mis_flag", 32'({mis_w, rw_w}), 32'h2);
        cycle(nop, 1'b0, 32'h0);
        check("lw_mis_once", 32'(mis_w), 32'h0);

        // Timeout: ready never arrives
        t = '0; t.alu = 32'h40; t.sel = 6'd2; t.mr = 1; t.rw = 1;
        cycle(t, 1'b0, 32'h0);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(nop, 1'b0, 32'h0);
            stalls += int'(s_stall);
        end
        check("to_stalls", 32'(stalls), 32'd4);
        check("to_fault", 32'({flt_w, rw_w}), 32'h2);
        cycle(nop, 1'b0, 32'h0);
        check("to_idle", 32'({s_stall, s_rd}), 32'h0);
        check("to_fault_once", 32'(flt_w), 32'h0);

        // Reset mid-access, then LHU at 0x002
        t = '0; t.alu = 32'h80; t.sel = 6'd2; t.mr = 1; t.rw = 1;
        cycle(t, 1'b0, 32'h0);
        cycle(nop, 1'b0, 32'h0);
        mid_reset();
        t = '0; t.alu = 32'h2; t.sel = 6'd5; t.mr = 1; t.rw = 1; t.wa = 5'd3;
        cycle(t, 1'b0, 32'h0);
        cycle(nop, 1'b1, 32'h8001_0000);
        check("lhu_data", load_w, 32'h0000_8001);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            cycle(rand_ins(), $urandom_range(0, 9) < 4, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
